// File: rtl/bcd_sum_sequencer_if.sv
// ---------------------------------------------------------------------------
// bcd_sum_sequencer_if
// Bundles the request, operand and result signals of bcd_sum_sequencer.
//   master : drives start, clear, a_bcd, b_bcd; observes the results
//   slave  : the sequencer itself
// Signals:
//   start     request to add, accepted only while busy = 0
//   clear     synchronous abort/clear, wins over start
//   a_bcd     operand A {A2,A1,A0}, digit 4'hF = blank
//   b_bcd     operand B {B2,B1,B0}
//   busy      operation in flight
//   done      one-cycle pulse when result or error is final
//   err       sticky invalid-operand flag
//   sum_bcd   {S3,S2,S1,S0}, leading zeros blanked to 4'hF
//   dbg_state current FSM state (0 IDLE, 1 LOAD, 2 ADD, 3 FMT)
// ---------------------------------------------------------------------------
interface bcd_sum_sequencer_if;
  logic        start;
  logic        clear;
  logic [11:0] a_bcd;
  logic [11:0] b_bcd;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] sum_bcd;
  logic [1:0]  dbg_state;

  modport master (
    output start, clear, a_bcd, b_bcd,
    input  busy, done, err, sum_bcd, dbg_state
  );

  modport slave (
    input  start, clear, a_bcd, b_bcd,
    output busy, done, err, sum_bcd, dbg_state
  );
endinterface

// File: rtl/bcd_sum_sequencer.sv
// ---------------------------------------------------------------------------
// bcd_sum_sequencer
// Digit-serial BCD adder between the keypad entry registers and the
// 7-segment display. Captures two 3-digit BCD operands, validates them,
// adds one digit per clock through a single 4-bit BCD adder stage, and
// presents a 4-digit leading-zero-blanked result.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-low reset
//   bus  bcd_sum_sequencer_if.slave (start/clear/operands in, status/result out)
//
// Request handshake: start is sampled on every rising edge. It is accepted
// only when busy = 0 at that edge; otherwise it is dropped, never queued.
// clear sampled high at an edge aborts everything and wins over start.
// An accepted start is answered by exactly one done pulse unless a clear
// or reset intervenes. busy is already 0 in the done cycle, so a new start
// may be accepted there.
// ---------------------------------------------------------------------------
module bcd_sum_sequencer (
  input  logic               clk,
  input  logic               rst,
  bcd_sum_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ADD  = 2'd2,
    S_FMT  = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [11:0] a_q;
  logic [11:0] b_q;
  logic [11:0] acc_q;
  logic [1:0]  idx_q;
  logic        carry_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] sum_q;

  logic        operand_bad;
  logic [3:0]  a_dig;
  logic [3:0]  b_dig;
  logic [4:0]  t_raw;
  logic [4:0]  t_adj;
  logic [3:0]  s_dig;
  logic        c_out;
  logic [15:0] fmt_sum;

  function automatic logic [3:0] dig_sel(input logic [11:0] v, input logic [1:0] i);
    case (i)
      2'd0:    dig_sel = v[3:0];
      2'd1:    dig_sel = v[7:4];
      2'd2:    dig_sel = v[11:8];
      default: dig_sel = 4'h0;
    endcase
  endfunction

  function automatic logic dig_bad(input logic [3:0] d);
    dig_bad = (d >= 4'hA) && (d <= 4'hE);
  endfunction

  // Blank digits (F) entered on the keypad count as zero.
  function automatic logic [11:0] unblank(input logic [11:0] v);
    unblank[3:0]  = (v[3:0]  == 4'hF) ? 4'h0 : v[3:0];
    unblank[7:4]  = (v[7:4]  == 4'hF) ? 4'h0 : v[7:4];
    unblank[11:8] = (v[11:8] == 4'hF) ? 4'h0 : v[11:8];
  endfunction

  // Operand validation, looked at on the raw latched codes.
  always_comb begin
    operand_bad = dig_bad(a_q[3:0]) | dig_bad(a_q[7:4]) | dig_bad(a_q[11:8]) |
                  dig_bad(b_q[3:0]) | dig_bad(b_q[7:4]) | dig_bad(b_q[11:8]);
  end

  // Shared single-digit BCD adder stage.
  always_comb begin
    a_dig = dig_sel(a_q, idx_q);
    b_dig = dig_sel(b_q, idx_q);
    t_raw = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
    t_adj = t_raw + 5'd6;
    if (t_raw > 5'd9) begin
      s_dig = t_adj[3:0];
      c_out = 1'b1;
    end else begin
      s_dig = t_raw[3:0];
      c_out = 1'b0;
    end
  end

  // Leading-zero blanking. S3 is only ever 0 or 1 (max 1998); each lower
  // digit may only blank if everything above it is already blank.
  always_comb begin
    logic s3_blank;
    logic s2_blank;
    logic s1_blank;
    s3_blank = ~carry_q;
    s2_blank = s3_blank && (acc_q[11:8] == 4'h0);
    s1_blank = s2_blank && (acc_q[7:4] == 4'h0);
    fmt_sum[15:12] = s3_blank ? 4'hF : 4'h1;
    fmt_sum[11:8]  = s2_blank ? 4'hF : acc_q[11:8];
    fmt_sum[7:4]   = s1_blank ? 4'hF : acc_q[7:4];
    fmt_sum[3:0]   = acc_q[3:0];
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) state_d = S_LOAD;
        S_LOAD: state_d = operand_bad ? S_IDLE : S_ADD;
        S_ADD:  if (idx_q == 2'd2) state_d = S_FMT;
        S_FMT:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: output decode.
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.dbg_state = state_q;
    bus.done      = done_q;
    bus.err       = err_q;
    bus.sum_bcd   = sum_q;
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= 12'h000;
      b_q     <= 12'h000;
      acc_q   <= 12'h000;
      idx_q   <= 2'd0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sum_q   <= 16'hFFFF;
    end else if (bus.clear) begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sum_q   <= 16'hFFFF;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a_bcd;
            b_q     <= bus.b_bcd;
            acc_q   <= 12'h000;
            idx_q   <= 2'd0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (operand_bad) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
            sum_q  <= 16'hFFFF;
          end else begin
            a_q <= unblank(a_q);
            b_q <= unblank(b_q);
          end
        end
        S_ADD: begin
          case (idx_q)
            2'd0:    acc_q[3:0]  <= s_dig;
            2'd1:    acc_q[7:4]  <= s_dig;
            2'd2:    acc_q[11:8] <= s_dig;
            default: acc_q       <= acc_q;
          endcase
          carry_q <= c_out;
          idx_q   <= idx_q + 2'd1;
        end
        S_FMT: begin
          sum_q  <= fmt_sum;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sum_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bcd_sum_sequencer
// Self-checking bench for bcd_sum_sequencer. Each accepted start pushes the
// expected {err, sum_bcd} and expected done cycle; a monitor pops them when
// done pulses and compares.
// ---------------------------------------------------------------------------
module tb_bcd_sum_sequencer;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;

  logic [16:0] exp_q[$];
  int          lat_q[$];

  bcd_sum_sequencer_if bus ();

  bcd_sum_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [16:0] e;
        int          l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check_eq("sum_bcd", {16'h0, bus.sum_bcd}, {16'h0, e[15:0]});
        check_eq("err", {31'h0, bus.err}, {31'h0, e[16]});
        check_eq("done_cycle", cyc, l);
        check_eq("busy_at_done", {31'h0, bus.busy}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Start in the current cycle (caller is between edges with busy = 0).
  task automatic start_now(input logic [11:0] a, input logic [11:0] b,
                           input logic [15:0] exp_sum, input logic exp_err,
                           input bit push);
    bus.a_bcd = a;
    bus.b_bcd = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      exp_q.push_back({exp_err, exp_sum});
      lat_q.push_back(cyc + (exp_err ? 1 : 5));
    end
    bus.start = 1'b0;
    // Latched copies must be used from here on.
    bus.a_bcd = 12'($urandom_range(0, 4095));
    bus.b_bcd = 12'($urandom_range(0, 4095));
    check_eq("busy_at_accept", {31'h0, bus.busy}, 32'd1);
    check_eq("err_cleared_at_accept", {31'h0, bus.err}, 32'd0);
  endtask

  task automatic start_op(input logic [11:0] a, input logic [11:0] b,
                          input logic [15:0] exp_sum, input logic exp_err);
    @(negedge clk);
    start_now(a, b, exp_sum, exp_err, 1'b1);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= max_cycles) check_eq("drain_timeout", n, 0);
    @(negedge clk);
  endtask

  task automatic wait_done(input int max_cycles);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.done !== 1'b1 && n < max_cycles);
    if (bus.done !== 1'b1) check_eq("done_timeout", n, 0);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [15:0] s;
    logic        e;
  } vec_t;

  vec_t vecs[5];

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.a_bcd = 12'h000;
    bus.b_bcd = 12'h000;

    // Reset held with random inputs.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.a_bcd = 12'($urandom_range(0, 4095));
      bus.b_bcd = 12'($urandom_range(0, 4095));
      @(negedge clk);
    end
    check_eq("rst_busy", {31'h0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'h0, bus.done}, 32'd0);
    check_eq("rst_err", {31'h0, bus.err}, 32'd0);
    check_eq("rst_sum", {16'h0, bus.sum_bcd}, 32'h0000_FFFF);
    check_eq("rst_state", {30'h0, bus.dbg_state}, 32'd0);
    bus.start = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle_busy", {31'h0, bus.busy}, 32'd0);
      check_eq("idle_sum", {16'h0, bus.sum_bcd}, 32'h0000_FFFF);
    end

    // 123 + 456 with cycle-by-cycle busy check.
    start_op(12'h123, 12'h456, 16'hF579, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_eq("busy_in_flight", {31'h0, bus.busy}, 32'd1);
      check_eq("sum_held", {16'h0, bus.sum_bcd}, 32'h0000_FFFF);
    end
    @(posedge clk);
    #1;
    check_eq("done_after_5", {31'h0, bus.done}, 32'd1);
    @(posedge clk);
    #1;
    check_eq("done_one_cycle", {31'h0, bus.done}, 32'd0);
    wait_drain(20);

    // Carry chain and blanking table.
    vecs[0] = '{12'h999, 12'h999, 16'h1998, 1'b0};
    vecs[1] = '{12'hFF5, 12'hFF7, 16'hFF12, 1'b0};
    vecs[2] = '{12'hFFF, 12'hFFF, 16'hFFF0, 1'b0};
    vecs[3] = '{12'h1A3, 12'h001, 16'hFFFF, 1'b1};
    vecs[4] = '{12'h001, 12'h002, 16'hFFF3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e);
      wait_drain(20);
      if (i == 3) begin
        repeat (3) @(negedge clk);
        check_eq("err_sticky", {31'h0, bus.err}, 32'd1);
      end
    end

    // Random valid operands against a decimal model.
    for (int i = 0; i < 8; i++) begin
      int va;
      int vb;
      int vs;
      logic [15:0] s;
      va = $urandom_range(0, 999);
      vb = $urandom_range(0, 999);
      vs = va + vb;
      s = {4'(vs / 1000), 4'((vs / 100) % 10), 4'((vs / 10) % 10), 4'(vs % 10)};
      if (vs < 1000) s[15:12] = 4'hF;
      if (vs < 100)  s[11:8]  = 4'hF;
      if (vs < 10)   s[7:4]   = 4'hF;
      start_op({4'(va / 100), 4'((va / 10) % 10), 4'(va % 10)},
               {4'(vb / 100), 4'((vb / 10) % 10), 4'(vb % 10)}, s, 1'b0);
      wait_drain(20);
    end

    // Contention: start during ADD ignored.
    start_op(12'h250, 12'h250, 16'hF500, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.a_bcd = 12'h111;
    bus.b_bcd = 12'h111;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_drain(20);

    // Start in the done cycle: back-to-back.
    start_op(12'h045, 12'h055, 16'hF100, 1'b0);
    wait_done(20);
    start_now(12'h300, 12'h400, 16'hF700, 1'b0, 1'b1);
    wait_drain(20);

    // Abort during ADD (i = 1).
    @(negedge clk);
    start_now(12'h777, 12'h111, 16'hF888, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    check_eq("clear_busy", {31'h0, bus.busy}, 32'd0);
    check_eq("clear_done", {31'h0, bus.done}, 32'd0);
    check_eq("clear_sum", {16'h0, bus.sum_bcd}, 32'h0000_FFFF);
    repeat (8) @(negedge clk);

    // clear and start together from IDLE: nothing starts.
    bus.start = 1'b1;
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    check_eq("clear_start_busy", {31'h0, bus.busy}, 32'd0);
    repeat (8) @(negedge clk);

    // Async reset mid-operation after a visible result.
    start_op(12'h010, 12'h020, 16'hFF30, 1'b0);
    wait_drain(20);
    @(negedge clk);
    start_now(12'h500, 12'h400, 16'hF900, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_eq("arst_busy", {31'h0, bus.busy}, 32'd0);
    check_eq("arst_sum", {16'h0, bus.sum_bcd}, 32'h0000_FFFF);
    check_eq("arst_err", {31'h0, bus.err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);

    check_eq("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_sum_sequencer.md
# bcd_sum_sequencer

Digit-serial BCD addition sequencer between the keypad entry registers and the multiplexed 7-segment display. It captures two 3-digit BCD operands on a start request and validates them. It then adds them one digit per clock through a single shared 4-bit BCD adder stage, and presents a 4-digit leading-zero-blanked result that feeds the display selection logic directly.

## Interface
- No parameters. Digit count is fixed at 3 operand digits and 4 result digits.
- Digit code 4'b1111 means "blank" on both inputs and outputs, matching the display driver.
- `clk  in  1`: system clock, 27 MHz.
- `rst  in  1`: reset. One clock; reset is asynchronous and active-low.
- `start  in  1`: request to add. Sampled each edge; accepted only when `busy`=0.
- `clear  in  1`: synchronous abort/clear from the '*' key path. Has priority over `start`.
- `a_bcd  in  12`: operand A, {A2,A1,A0}, hundreds:tens:units.
- `b_bcd  in  12`: operand B, {B2,B1,B0}.
- `busy  out  1`: high while an operation is in flight.
- `done  out  1`: one-cycle pulse when the result or error is final.
- `err  out  1`: sticky invalid-operand flag.
- `sum_bcd  out  16`: result {S3,S2,S1,S0}, blanked as described below.

## Operation
- FSM states: IDLE, LOAD, ADD, FMT.
- IDLE to LOAD:
  - Occurs on `start`=1 with `clear`=0.
  - Latches `a_bcd` and `b_bcd` into internal operand registers.
  - Digit index = 0, carry = 0.
  - Clears `err`.
- LOAD (validation):
  - Each operand digit maps blank (F) to 0.
  - Digits 4'hA to 4'hE are invalid.
  - Any invalid digit: go to IDLE, set `err`=1, pulse `done`, set `sum_bcd`=16'hFFFF.
  - Otherwise go to ADD.
- ADD, one digit per cycle, i = 0,1,2:
  - t = a_i + b_i + c, computed 5 bits wide.
  - If t > 9: s_i = t + 6 (low 4 bits), c = 1.
  - Else: s_i = t, c = 0.
  - s_i is written into the internal accumulator.
  - After i = 2, go to FMT.
- FMT:
  - S3 = final carry.
  - Leading-zero blanking: S3 is blank if 0. S2 is blank if S3 is blank and S2 = 0. S1 is blank if S2 is blank and S1 = 0.
  - S0 is never blanked.
  - Write the blanked value to `sum_bcd`, pulse `done`, go to IDLE.
- `sum_bcd` holds its previous value for the whole operation. It updates only in the cycle `done` rises.
- `start` while `busy`=1 is ignored. It is not queued.
- `clear`=1 in any state, on the next edge:
  - state = IDLE; `busy`=0; `done`=0; `err`=0; `sum_bcd`=16'hFFFF.
  - Any in-flight result is discarded.
- `start` and `clear` in the same cycle: `clear` wins and `start` is dropped.
- Operand inputs may change freely after the accepting edge; only latched copies are used.
- Max result 999+999 = 1998. S3 is therefore only ever 0 or 1, and no overflow case exists.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `err`=0, `sum_bcd`=16'hFFFF, internal registers 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Let edge N be the edge at which `start` is accepted.
- Valid operands:
  - `busy`=1 after edges N through N+4.
  - After edge N+5: `busy`=0, `done`=1 for exactly one cycle, `sum_bcd` is new.
  - Latency: 5 edges from accept to result.
- Invalid operands: after edge N+1, `busy`=0, `done`=1 (one cycle), `err`=1, `sum_bcd`=16'hFFFF.
- Back-to-back operation: a new `start` is accepted in the same cycle `done`=1, because `busy` is already 0.
- `err` stays 1 until the next accepted `start`, a `clear`, or reset.
- Reset assertion mid-operation returns all outputs to reset values immediately and asynchronously.

## Test plan
- Reset: hold `rst`=0 with random inputs -> `busy`=0, `done`=0, `err`=0, `sum_bcd`=16'hFFFF. Release, no `start` -> outputs unchanged for 20 cycles.
- `a_bcd`=12'h123, `b_bcd`=12'h456, `start` pulse at edge N -> `busy` high for 5 cycles, `done` single pulse after N+5, `sum_bcd`=16'hF579, `err`=0.
- Carry chain: 12'h999 + 12'h999 -> 16'h1998. Then 12'hFF5 + 12'hFF7 -> 16'hFF12. Then 12'hFFF + 12'hFFF -> 16'hFFF0.
- Invalid digit: `a_bcd`=12'h1A3, `b_bcd`=12'h001 -> `done` after N+1, `err`=1, `sum_bcd`=16'hFFFF. Next valid start (12'h001+12'h002) -> `err` clears at accept, result 16'hFFF3.
- Contention: `start` re-asserted during ADD with different operands -> ignored, first result delivered unchanged. `start` in the `done` cycle -> accepted, second result follows 5 edges later.
- Abort: `clear` asserted during ADD (i=1) -> next edge `busy`=0, `sum_bcd`=16'hFFFF, no `done` pulse. `clear` and `start` in the same cycle from IDLE -> no operation starts.
